fb_write_arbiter: RTL and testbench

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

---
 rtl/fb_write_arbiter_pkg.sv | 41 ++++
 rtl/fb_write_arbiter_if.sv | 30 +++
 rtl/fb_write_arbiter_rr.sv | 17 +
 rtl/fb_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_fb_write_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_write_arbiter_pkg.sv
// Shared constants and helpers for the frame-buffer write arbiter.
// Holds the default frame geometry, the FSM state encodings and the
// round-robin pick function used by rr_arbiter3.
package fb_pkg;

  // Default frame geometry and bus widths
  localparam int WIDTH     = 640;
  localparam int HEIGHT    = 480;
  localparam int AW        = 19;
  localparam int DW        = 12;
  localparam int FB_PIXELS = WIDTH * HEIGHT;

  // Arbiter FSM states (plain constants so legacy tools can consume them)
  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Round-robin winner among three requesters: the search starts at the
  // requester after the last winner and wraps 2 -> 0. A last value of 3
  // never occurs in normal operation and is treated like 2.
  function automatic logic [2:0] rr_pick(input logic [2:0] valid,
                                         input logic [1:0] last);
    logic [2:0] grant;
    logic [1:0] idx;
    grant = 3'b000;
    idx   = last;
    for (int k = 0; k < 3; k++) begin
      idx = (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
      if ((grant == 3'b000) && valid[idx]) begin
        grant[idx] = 1'b1;
      end
    end
    return grant;
  endfunction

  // Index of a one-hot grant vector. An all-zero vector maps to 0; callers
  // only use the index when the grant is non-zero.
  function automatic logic [1:0] grant_index(input logic [2:0] grant);
    return grant[2] ? 2'd2 : (grant[1] ? 2'd1 : 2'd0);
  endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Requester-side write bus of the frame-buffer arbiter.
// Three requesters share the packed valid/addr/data vectors; the arbiter
// answers with a one-hot (or all-zero) ready vector.
interface fb_write_arbiter_if #(
  parameter int AW = fb_pkg::AW,
  parameter int DW = fb_pkg::DW
);

  logic [2:0]      req_valid;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_data;
  logic [2:0]      req_ready;

  // Requester side: offers writes, observes accepts
  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  // Arbiter side: observes offers, issues accepts
  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/fb_write_arbiter_rr.sv
// Three-way round-robin selector.
// Purely combinational: given the asserted requests and the last winner,
// returns the one-hot grant for the next winner, or zero if none is valid.
module rr_arbiter3
  import fb_pkg::*;
(
  input  logic [2:0] valid,
  input  logic [1:0] last,
  output logic [2:0] grant
);

  // Search from the requester after the last winner
  always_comb begin
    grant = rr_pick(valid, last);
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write arbiter.
// Merges three pixel-write requesters onto one registered frame-buffer
// write port with round-robin fairness, optional restriction of requester
// writes to vertical blank, and a full-frame fill engine that owns the
// port for WIDTH*HEIGHT consecutive cycles.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int WIDTH  = fb_pkg::WIDTH,
  parameter int HEIGHT = fb_pkg::HEIGHT,
  parameter int AW     = fb_pkg::AW,
  parameter int DW     = fb_pkg::DW
) (
  input  logic              clk,
  input  logic              rstn,
  fb_write_arbiter_if.slave req,
  input  logic              clr_start,
  input  logic [DW-1:0]     clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              gate_en,
  input  logic              vblank,
  output logic              fb_we,
  output logic [AW-1:0]     fb_addr,
  output logic [DW-1:0]     fb_din
);

  // Last pixel address of the frame; the fill counter stops here
  localparam int            PIXELS    = WIDTH * HEIGHT;
  localparam logic [AW-1:0] FILL_LAST = AW'(PIXELS - 1);

  // Registered state
  logic [0:0]    state_q,     state_d;
  logic [AW-1:0] fill_cnt_q,  fill_cnt_d;
  logic [DW-1:0] color_q,     color_d;
  logic [1:0]    last_q,      last_d;
  logic          fb_we_q,     fb_we_d;
  logic [AW-1:0] fb_addr_q,   fb_addr_d;
  logic [DW-1:0] fb_din_q,    fb_din_d;
  logic          clr_done_q,  clr_done_d;

  // Arbitration signals
  logic [2:0] rr_grant;
  logic [2:0] ready;
  logic       arb_block;
  logic       accept;
  logic [1:0] acc_idx;
  logic       fill_last;

  rr_arbiter3 u_rr (
    .valid (req.req_valid),
    .last  (last_q),
    .grant (rr_grant)
  );

  // Requester accept: suppressed during a fill, on the cycle a fill is
  // requested, and outside vertical blank when gating is enabled
  always_comb begin
    arb_block = (state_q == ST_CLEAR) || clr_start || (gate_en && !vblank);
    ready     = arb_block ? 3'b000 : rr_grant;
    accept    = |(ready & req.req_valid);
    acc_idx   = grant_index(ready);
    fill_last = (fill_cnt_q == FILL_LAST);
  end

  assign req.req_ready = ready;

  // Next-state logic for the FSM, fill counter and write port
  always_comb begin
    // NOTE: every _d signal takes a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    color_d    = color_q;
    last_d     = last_q;
    fb_we_d    = 1'b0;
    fb_addr_d  = fb_addr_q;
    fb_din_d   = fb_din_q;
    clr_done_d = 1'b0;

    case (state_q)
      ST_ARB: begin
        if (clr_start) begin
          // Start a fill: colour is captured now, later changes are ignored
          state_d    = ST_CLEAR;
          fill_cnt_d = '0;
          color_d    = clr_color;
        end else if (accept) begin
          // Requester address and data pass through untouched
          fb_we_d   = 1'b1;
          fb_addr_d = req.req_addr[acc_idx * AW +: AW];
          fb_din_d  = req.req_data[acc_idx * DW +: DW];
          last_d    = acc_idx;
        end
      end

      ST_CLEAR: begin
        // One fill write per cycle regardless of gate_en/vblank
        fb_we_d   = 1'b1;
        fb_addr_d = fill_cnt_q;
        fb_din_d  = color_q;
        if (fill_last) begin
          state_d    = ST_ARB;
          clr_done_d = 1'b1;
        end else begin
          fill_cnt_d = fill_cnt_q + AW'(1);
        end
      end

      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // State registers; reset aborts any fill in progress without a done pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_ARB;
      fill_cnt_q <= '0;
      color_q    <= '0;
      last_q     <= 2'd2;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_din_q   <= '0;
      clr_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // that existed before this edge, independent of statement order.
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      color_q    <= color_d;
      last_q     <= last_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_din_q   <= fb_din_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_din   = fb_din_q;
  assign clr_done = clr_done_q;
  assign clr_busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter.
// Each stimulus cycle pushes the expected write-port contents for the
// following cycle into a scoreboard queue; a monitor pops and compares one
// entry per cycle just after the clock edge. The frame is shrunk to 64x32
// so full fills stay short.
module tb_fb_write_arbiter;

  localparam int TB_W      = 64;
  localparam int TB_H      = 32;
  localparam int AW        = 19;
  localparam int DW        = 12;
  localparam int FILL_LAST = TB_W * TB_H - 1;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          busy;
    logic          done;
  } exp_t;

  logic          clk;
  logic          rstn;
  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy;
  logic          clr_done;
  logic          gate_en;
  logic          vblank;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [DW-1:0] fb_din;

  fb_write_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  fb_write_arbiter #(
    .WIDTH  (TB_W),
    .HEIGHT (TB_H),
    .AW     (AW),
    .DW     (DW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (bus),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .gate_en   (gate_en),
    .vblank    (vblank),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_din    (fb_din)
  );

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            exp_last = 2;
  logic [AW-1:0] ra[3];
  logic [DW-1:0] rd[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference round-robin: first valid requester after the last winner
  function automatic int model_grant_idx(input logic [2:0] v, input int last);
    for (int off = 1; off <= 3; off++) begin
      int i;
      i = (last + off) % 3;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Write-port monitor: one scoreboard entry per cycle while entries exist
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if (fb_we !== e.we || clr_busy !== e.busy || clr_done !== e.done ||
          (e.we && (fb_addr !== e.addr || fb_din !== e.din))) begin
        n_errors++;
        $display("FAIL fb_port @%0t: got we=%b addr=%h din=%h busy=%b done=%b, expected we=%b addr=%h din=%h busy=%b done=%b",
                 $time, fb_we, fb_addr, fb_din, clr_busy, clr_done,
                 e.we, e.addr, e.din, e.busy, e.done);
      end
    end
  end

  // One arbitration cycle: drive, compare req_ready against the model,
  // and queue the expected write for the next cycle
  task automatic arb_cycle(input logic [2:0] v, input logic gate, input logic vb);
    logic [2:0] exp_ready;
    int         idx;
    exp_t       e;
    @(posedge clk);
    #2;
    bus.req_valid = v;
    bus.req_addr  = {ra[2], ra[1], ra[0]};
    bus.req_data  = {rd[2], rd[1], rd[0]};
    gate_en       = gate;
    vblank        = vb;
    clr_start     = 1'b0;
    #2;
    idx       = (gate && !vb) ? -1 : model_grant_idx(v, exp_last);
    exp_ready = 3'b000;
    if (idx >= 0) exp_ready[idx] = 1'b1;
    n_checks++;
    if (bus.req_ready !== exp_ready) begin
      n_errors++;
      $display("FAIL req_ready @%0t: got %b expected %b (valid %b gate %b vblank %b)",
               $time, bus.req_ready, exp_ready, v, gate, vb);
    end
    e.we   = (idx >= 0);
    e.addr = (idx >= 0) ? ra[idx] : '0;
    e.din  = (idx >= 0) ? rd[idx] : '0;
    e.busy = 1'b0;
    e.done = 1'b0;
    sb.push_back(e);
    if (idx >= 0) exp_last = idx;
  endtask

  // Fill sequence: clr_start cycle, then one expected write per address.
  // A spurious clr_start and a colour change are injected mid-fill.
  // Stops after issuing address stop_at when stop_at >= 0.
  task automatic fill_run(input logic [DW-1:0] color, input logic [2:0] v,
                          input int stop_at);
    exp_t e;
    @(posedge clk);
    #2;
    clr_start     = 1'b1;
    clr_color     = color;
    bus.req_valid = v;
    gate_en       = 1'b0;
    vblank        = 1'b0;
    #2;
    n_checks++;
    if (bus.req_ready !== 3'b000) begin
      n_errors++;
      $display("FAIL ready_on_clr_start @%0t: got %b expected 000", $time, bus.req_ready);
    end
    e = '{we: 1'b0, addr: '0, din: '0, busy: 1'b1, done: 1'b0};
    sb.push_back(e);
    for (int i = 0; i <= FILL_LAST; i++) begin
      @(posedge clk);
      #2;
      clr_start = (i == 5);
      if (i == 5) clr_color = ~color;
      #2;
      n_checks++;
      if (bus.req_ready !== 3'b000) begin
        n_errors++;
        $display("FAIL ready_during_fill @%0t: got %b expected 000 (fill %0d)",
                 $time, bus.req_ready, i);
      end
      e = '{we: 1'b1, addr: AW'(i), din: color,
            busy: (i != FILL_LAST), done: (i == FILL_LAST)};
      sb.push_back(e);
      if (i == stop_at) break;
    end
    clr_start = 1'b0;
  endtask

  task automatic test_reset();
    rstn          = 1'b0;
    bus.req_valid = 3'b111;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if ({fb_we, fb_addr, fb_din, clr_busy, clr_done} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got we=%b addr=%h din=%h busy=%b done=%b expected all zero",
               fb_we, fb_addr, fb_din, clr_busy, clr_done);
    end
    // last_grant resets to 2, so requester 0 is first in line
    n_checks++;
    if (bus.req_ready !== 3'b001) begin
      n_errors++;
      $display("FAIL reset_ready: got %b expected 001", bus.req_ready);
    end
    bus.req_valid = 3'b000;
    @(posedge clk);
    #2;
    rstn     = 1'b1;
    exp_last = 2;
  endtask

  task automatic test_round_robin();
    logic [2:0] seq [6];
    seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int k = 0; k < 3; k++) begin
      ra[k] = AW'(19'h00100 + k);
      rd[k] = DW'(12'h100 + k);
    end
    for (int c = 0; c < 6; c++) begin
      arb_cycle(3'b111, 1'b0, 1'b0);
      n_checks++;
      if (bus.req_ready !== seq[c]) begin
        n_errors++;
        $display("FAIL rr_sequence[%0d]: got %b expected %b", c, bus.req_ready, seq[c]);
      end
    end
    arb_cycle(3'b000, 1'b0, 1'b0);
  endtask

  task automatic test_passthrough();
    ra[1] = 19'h12C00;
    rd[1] = 12'hF00;
    arb_cycle(3'b010, 1'b0, 1'b0);
    arb_cycle(3'b000, 1'b0, 1'b0);
    // Random mix of requests, data and gating
    for (int c = 0; c < 24; c++) begin
      for (int k = 0; k < 3; k++) begin
        ra[k] = AW'($urandom);
        rd[k] = DW'($urandom);
      end
      arb_cycle(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end
    arb_cycle(3'b000, 1'b0, 1'b0);
  endtask

  task automatic test_gate();
    ra[0] = 19'h00ABC;
    rd[0] = 12'h0A5;
    for (int c = 0; c < 10; c++) begin
      arb_cycle(3'b001, 1'b1, 1'b0);
    end
    arb_cycle(3'b001, 1'b1, 1'b1);
    n_checks++;
    if (bus.req_ready !== 3'b001) begin
      n_errors++;
      $display("FAIL gate_vblank_open: got %b expected 001", bus.req_ready);
    end
    arb_cycle(3'b000, 1'b0, 1'b0);
  endtask

  task automatic test_clear();
    fill_run(12'h0F0, 3'b111, -1);
    arb_cycle(3'b000, 1'b0, 1'b0);
    arb_cycle(3'b000, 1'b0, 1'b0);
  endtask

  task automatic test_clear_collision();
    ra[2] = 19'h4B000;
    rd[2] = 12'h00F;
    fill_run(12'hABC, 3'b100, -1);
    // First cycle with clr_busy low: the waiting requester goes through
    arb_cycle(3'b100, 1'b0, 1'b0);
    n_checks++;
    if (bus.req_ready !== 3'b100) begin
      n_errors++;
      $display("FAIL collision_accept: got %b expected 100", bus.req_ready);
    end
    arb_cycle(3'b000, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_fill();
    fill_run(12'h00F, 3'b000, 1000);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({fb_we, clr_busy, clr_done} !== 3'b000 || fb_addr !== '0) begin
      n_errors++;
      $display("FAIL reset_abort: got we=%b busy=%b done=%b addr=%h expected 0 0 0 0",
               fb_we, clr_busy, clr_done, fb_addr);
    end
    repeat (2) @(posedge clk);
    #2;
    rstn     = 1'b1;
    exp_last = 2;
    // No late done pulse after the aborted fill
    repeat (3) arb_cycle(3'b000, 1'b0, 1'b0);
    fill_run(12'h555, 3'b000, -1);
    arb_cycle(3'b000, 1'b0, 1'b0);
  endtask

  initial begin
    rstn          = 1'b0;
    clr_start     = 1'b0;
    clr_color     = '0;
    gate_en       = 1'b0;
    vblank        = 1'b0;
    bus.req_valid = 3'b000;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    for (int k = 0; k < 3; k++) begin
      ra[k] = '0;
      rd[k] = '0;
    end

    test_reset();
    test_round_robin();
    test_passthrough();
    test_gate();
    test_clear();
    test_clear_collision();
    test_reset_mid_fill();

    repeat (3) @(posedge clk);
    #3;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so a stuck run still terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
